tube_scan_driver: RTL and testbench

//  Time-multiplexed driver for one 4-digit 7-segment tube group.
//  - Consumes the 16-bit hex value held by the tube MMIO peripheral; drives the board sel/seg pins.
//  - Digits are scanned one at a time with a blank guard gap between them to suppress ghosting.
//  - A frame-start shadow copy of the data prevents tearing when the CPU writes mid-frame.

---
 rtl/tube_scan_driver_pkg.sv | 46 ++++
 rtl/tube_scan_driver_decode.sv | 12 +
 rtl/tube_scan_driver.sv | 158 +++++++++++++++
 tb/tb_tube_scan_driver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_scan_driver_pkg.sv
// Shared types, constants and helpers for the 4-digit tube scan driver.
// Segment codes here are active-high {dp,g,f,e,d,c,b,a}.
package tube_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [6:0] hex_segs(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Bit k set when nibbles k..3 are all zero; digit 0 never blanks.
    function automatic logic [3:0] lz_mask(input logic [15:0] d);
        logic [3:0] m;
        m[3] = (d[15:12] == 4'h0);
        m[2] = m[3] && (d[11:8] == 4'h0);
        m[1] = m[2] && (d[7:4] == 4'h0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/tube_scan_driver_decode.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
import tube_scan_driver_pkg::*;

module hex7seg_decode (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, hex_segs(nibble)};

endmodule

// File: rtl/tube_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with guard gaps,
// frame-start shadowing and optional leading-zero blanking.
import tube_scan_driver_pkg::*;

module tube_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter int GAP_CYC        = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    output logic [3:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int MAXC = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int CW   = $clog2((MAXC < 2) ? 2 : MAXC);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  =
        (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    localparam logic [3:0] SEL_OFF = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0] SEG_OFF =
        SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          fs;

    logic [15:0]   sh_data;
    logic [3:0]    sh_dp;
    logic          sh_blz;

    logic [15:0]   src_data;
    logic [3:0]    src_dp;
    logic          src_blz;
    logic [3:0]    lz;
    logic [3:0]    nib;
    logic [7:0]    dec_seg;
    logic [7:0]    seg_hi;
    logic [3:0]    sel_hi;
    logic [3:0]    sel_d;
    logic [7:0]    seg_d;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        fs      = 1'b0;
        unique case (state)
            ST_OFF: begin
                cnt_n = '0;
                idx_n = 2'd0;
                if (en) begin
                    state_n = ST_ON;
                    fs      = 1'b1;
                end
            end
            ST_ON: begin
                if (cnt == SCAN_LAST) begin
                    cnt_n = '0;
                    if (GAP_CYC > 0) begin
                        state_n = ST_GAP;
                    end else begin
                        idx_n = idx + 1'b1;
                        fs    = (idx == 2'd3);
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_ON;
                    idx_n   = idx + 1'b1;
                    fs      = (idx == 2'd3);
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_OFF;
                cnt_n   = '0;
                idx_n   = 2'd0;
            end
        endcase
        // Disable aborts mid-digit; the next enable starts a fresh frame.
        if (!en) begin
            state_n = ST_OFF;
            idx_n   = 2'd0;
            cnt_n   = '0;
            fs      = 1'b0;
        end
    end

    // On frame start decode straight from the inputs being captured.
    assign src_data = fs ? data     : sh_data;
    assign src_dp   = fs ? dp       : sh_dp;
    assign src_blz  = fs ? blank_lz : sh_blz;
    assign lz       = lz_mask(src_data);
    assign nib      = src_data[{idx_n, 2'b00} +: 4];

    hex7seg_decode u_dec (
        .nibble (nib),
        .dp     (src_dp[idx_n]),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_hi = dec_seg;
        if (src_blz && lz[idx_n]) begin
            seg_hi = SEG_BLANK | {src_dp[idx_n], 7'b0};
        end
        sel_hi = 4'b0001 << idx_n;
        sel_d  = SEL_OFF;
        seg_d  = SEG_OFF;
        if (state_n == ST_ON) begin
            sel_d = SEL_ACTIVE_LOW ? ~sel_hi : sel_hi;
            seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_OFF;
            idx        <= 2'd0;
            cnt        <= '0;
            sh_data    <= 16'h0;
            sh_dp      <= 4'h0;
            sh_blz     <= 1'b0;
            sel        <= SEL_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            sel        <= sel_d;
            seg        <= seg_d;
            frame_tick <= fs;
            if (fs) begin
                sh_data <= data;
                sh_dp   <= dp;
                sh_blz  <= blank_lz;
            end
        end
    end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Directed self-checking bench for tube_scan_driver (SCAN_DIV=4, GAP_CYC=1),
// plus inverted-polarity and SCAN_DIV=1 instances.
module tb_tube_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blank_lz;

    logic [3:0]  sel, sel_i, sel_f;
    logic [7:0]  seg, seg_i, seg_f;
    logic        frame_tick, ft_i, ft_f;

    int checks = 0;
    int errors = 0;

    // Active-low hex codes 0..F with dp off.
    localparam logic [7:0] AL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    always #5 clk = ~clk;

    tube_scan_driver #(
        .SCAN_DIV(4), .GAP_CYC(1),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .data(data), .dp(dp),
        .blank_lz(blank_lz), .sel(sel), .seg(seg),
        .frame_tick(frame_tick)
    );

    tube_scan_driver #(
        .SCAN_DIV(4), .GAP_CYC(1),
        .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b1)
    ) u_inv (
        .clk(clk), .reset(reset), .en(en), .data(data), .dp(dp),
        .blank_lz(blank_lz), .sel(sel_i), .seg(seg_i),
        .frame_tick(ft_i)
    );

    tube_scan_driver #(
        .SCAN_DIV(1), .GAP_CYC(0),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
    ) u_fast (
        .clk(clk), .reset(reset), .en(en), .data(data), .dp(dp),
        .blank_lz(blank_lz), .sel(sel_f), .seg(seg_f),
        .frame_tick(ft_f)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] xsel(input int e);
        int p;
        p = (e - 1) % 5;
        return (p < 4) ? (4'b0001 << ((e - 1) / 5)) : 4'b0000;
    endfunction

    function automatic logic [7:0] xseg(input logic [15:0] d,
                                        input int e);
        int p;
        int k;
        p = (e - 1) % 5;
        k = (e - 1) / 5;
        return (p < 4) ? AL[d[k*4 +: 4]] : 8'hFF;
    endfunction

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; data = 16'h1234;
        dp = 4'h0; blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (sel !== 4'b0000 || seg !== 8'hFF || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset: sel=%b seg=%h ft=%b want 0000 ff 0",
                         sel, seg, frame_tick);
            end
            checks++;
            if (sel_i !== 4'b1111 || seg_i !== 8'h00) begin
                errors++;
                $display("FAIL reset_inv: sel=%b seg=%h want 1111 00",
                         sel_i, seg_i);
            end
        end
    endtask

    task automatic test_scan();
        reset = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            int fe;
            step();
            fe = ((e - 1) % 20) + 1;
            checks++;
            if (sel !== xsel(fe) || seg !== xseg(16'h1234, fe)
                || frame_tick !== (fe == 1)) begin
                errors++;
                $display("FAIL scan e%0d: sel=%b seg=%h ft=%b want %b %h %b",
                         e, sel, seg, frame_tick, xsel(fe),
                         xseg(16'h1234, fe), fe == 1);
            end
        end
    endtask

    task automatic test_tearing();
        for (int e = 2; e <= 20; e++) begin
            step();
            checks++;
            if (sel !== xsel(e) || seg !== xseg(16'h1234, e)
                || frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL tear_old e%0d: sel=%b seg=%h want %b %h",
                         e, sel, seg, xsel(e), xseg(16'h1234, e));
            end
            if (e == 11) data = 16'hABCD;
        end
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if (sel !== xsel(e) || seg !== xseg(16'hABCD, e)
                || frame_tick !== (e == 1)) begin
                errors++;
                $display("FAIL tear_new e%0d: sel=%b seg=%h ft=%b want %b %h",
                         e, sel, seg, frame_tick, xsel(e),
                         xseg(16'hABCD, e));
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [7:0] want [4];
        want[0] = 8'hC0; want[1] = 8'h92;
        want[2] = 8'hFF; want[3] = 8'h7F;
        blank_lz = 1'b1; data = 16'h0050; dp = 4'b1000;
        for (int e = 1; e <= 20; e++) begin
            logic [7:0] ws;
            step();
            ws = (((e - 1) % 5) < 4) ? want[(e - 1) / 5] : 8'hFF;
            checks++;
            if (sel !== xsel(e) || seg !== ws) begin
                errors++;
                $display("FAIL blank_lz e%0d: sel=%b seg=%h want %b %h",
                         e, sel, seg, xsel(e), ws);
            end
        end
    endtask

    task automatic test_en_toggle();
        blank_lz = 1'b0; dp = 4'h0; data = 16'h1234;
        step();
        checks++;
        if (frame_tick !== 1'b1 || seg !== 8'h99) begin
            errors++;
            $display("FAIL en_pre: ft=%b seg=%h want 1 99", frame_tick, seg);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (sel !== 4'b0010 || seg !== 8'hB0) begin
            errors++;
            $display("FAIL en_mid: sel=%b seg=%h want 0010 b0", sel, seg);
        end
        data = 16'h5678; en = 1'b0;
        step();
        checks++;
        if (sel !== 4'b0000 || seg !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL en_off: sel=%b seg=%h ft=%b want 0000 ff 0",
                     sel, seg, frame_tick);
        end
        en = 1'b1;
        step();
        checks++;
        if (sel !== 4'b0001 || seg !== 8'h80 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL en_restart: sel=%b seg=%h ft=%b want 0001 80 1",
                     sel, seg, frame_tick);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (sel !== 4'b0010 || seg !== 8'hF8) begin
            errors++;
            $display("FAIL en_digit1: sel=%b seg=%h want 0010 f8", sel, seg);
        end
    endtask

    task automatic test_mid_reset();
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (sel !== 4'b0000 || seg !== 8'hFF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: sel=%b seg=%h ft=%b want 0000 ff 0",
                     sel, seg, frame_tick);
        end
        reset = 1'b0;
        step();
        checks++;
        if (sel !== 4'b0001 || seg !== 8'h80 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: sel=%b seg=%h ft=%b want 0001 80 1",
                     sel, seg, frame_tick);
        end
    endtask

    task automatic test_inverted();
        reset = 1'b1; data = 16'h0008;
        step();
        checks++;
        if (sel_i !== 4'b1111 || seg_i !== 8'h00 || ft_i !== 1'b0) begin
            errors++;
            $display("FAIL inv_reset: sel=%b seg=%h want 1111 00",
                     sel_i, seg_i);
        end
        reset = 1'b0;
        step();
        checks++;
        if (sel_i !== 4'b1110 || seg_i !== 8'h7F || ft_i !== 1'b1) begin
            errors++;
            $display("FAIL inv_digit0: sel=%b seg=%h ft=%b want 1110 7f 1",
                     sel_i, seg_i, ft_i);
        end
    endtask

    task automatic test_fast_scan();
        reset = 1'b1; data = 16'h1234;
        step();
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            logic [3:0] ws;
            logic [7:0] wg;
            int k;
            step();
            k  = (e - 1) % 4;
            ws = 4'b0001 << k;
            wg = AL[data[k*4 +: 4]];
            checks++;
            if (sel_f !== ws || seg_f !== wg
                || ft_f !== (e == 1 || e == 5)) begin
                errors++;
                $display("FAIL fast e%0d: sel=%b seg=%h ft=%b want %b %h",
                         e, sel_f, seg_f, ft_f, ws, wg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearing();
        test_blank_lz();
        test_en_toggle();
        test_mid_reset();
        test_inverted();
        test_fast_scan();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
